// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF/ON/BLINK/PWM driven from
// a shared blink prescaler and a shared PWM counter, with a global phase resync.
module led_pattern_gen #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned HALF_PERIOD = 5_000_000,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned PWM_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*NUM_CH-1:0]       mode,
    input  logic [PWM_W*NUM_CH-1:0]   duty,
    input  logic                      sync_req,
    output logic [NUM_CH-1:0]         led,
    output logic                      tick
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] PRESC_TC = CNT_W'(HALF_PERIOD - 32'd1);
    localparam logic [PWM_W-1:0] PWM_TC   = PWM_W'((32'd1 << PWM_W) - 32'd2);

    logic [CNT_W-1:0]  presc_q, presc_d;
    logic              phase_q, phase_d;
    logic [PWM_W-1:0]  pwm_q,   pwm_d;
    logic              tick_q,  tick_d;
    logic [NUM_CH-1:0] led_q,   led_d;
    logic              presc_tc_c;

    // Shared timebase; a resync request overrides the terminal-count wrap.
    always_comb begin
        presc_tc_c = (presc_q == PRESC_TC);
        presc_d    = presc_tc_c ? '0 : presc_q + CNT_W'(1);
        phase_d    = phase_q ^ presc_tc_c;
        pwm_d      = (pwm_q == PWM_TC) ? '0 : pwm_q + PWM_W'(1);
        tick_d     = presc_tc_c;
        if (sync_req) begin
            presc_d = '0;
            phase_d = 1'b0;
            pwm_d   = '0;
            tick_d  = 1'b0;
        end
    end

    // Per-channel drive from the current (pre-update) counter state.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            case (mode_e'(mode[2*i +: 2]))
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = phase_q;
                MODE_PWM:   led_d[i] = (pwm_q < duty[PWM_W*i +: PWM_W]);
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            phase_q <= 1'b0;
            pwm_q   <= '0;
            tick_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed scenarios plus random traffic
// checked against an arithmetic model based on clocks elapsed since the last restart.
module tb_led_pattern_gen;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned HP      = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PWM_W   = 3;
    localparam int          PWM_PER = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync_req;
    logic [7:0]  mode;
    logic [11:0] duty;
    logic [3:0]  led;
    logic        tick;

    int checks = 0;
    int fails  = 0;
    int t      = 0;   // rising edges since the last reset/resync edge

    led_pattern_gen #(
        .NUM_CH(NUM_CH), .HALF_PERIOD(HP), .CNT_W(CNT_W), .PWM_W(PWM_W)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .duty(duty),
        .sync_req(sync_req), .led(led), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_led(input logic [7:0] m, input logic [11:0] d, input int tt);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            case (m[2*i +: 2])
                2'b00:   r[i] = 1'b0;
                2'b01:   r[i] = 1'b1;
                2'b10:   r[i] = ((tt / int'(HP)) % 2) == 1;
                default: r[i] = (tt % PWM_PER) < int'(d[3*i +: 3]);
            endcase
        end
        return r;
    endfunction

    task automatic step(input logic r, input logic s, input logic [7:0] m, input logic [11:0] d);
        logic [3:0] exp_led;
        logic       exp_tick;
        rst = r; sync_req = s; mode = m; duty = d;
        if (r) begin
            exp_led = '0; exp_tick = 1'b0; t = 0;
        end else begin
            exp_led = model_led(m, d, t);
            if (s) begin
                t = 0; exp_tick = 1'b0;
            end else begin
                t = t + 1; exp_tick = (t % int'(HP)) == 0;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        assert (led === exp_led) else begin
            fails++;
            $error("FAIL led observed=%b expected=%b (t=%0d)", led, exp_led, t);
        end
        checks++;
        assert (tick === exp_tick) else begin
            fails++;
            $error("FAIL tick observed=%b expected=%b (t=%0d)", tick, exp_tick, t);
        end
    endtask

    initial begin
        int highs;
        int k;
        logic [7:0]  rm;
        logic [11:0] rd;
        rst = 1'b1; sync_req = 1'b0; mode = '0; duty = '0;

        // Reset with all channels in BLINK, then free-run the blink pattern.
        step(1'b1, 1'b0, 8'hAA, 12'h000);
        step(1'b1, 1'b1, 8'hAA, 12'h000);
        checks++;
        assert (led === 4'b0000 && tick === 1'b0) else begin
            fails++;
            $error("FAIL reset_state observed=%b/%b expected=0000/0", led, tick);
        end
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'hAA, 12'h000);

        // PWM duties 3/0/7 with ch3 OFF, resynced so the period starts cleanly.
        step(1'b0, 1'b1, 8'h3F, {3'd0, 3'd7, 3'd0, 3'd3});
        highs = 0;
        for (int i = 0; i < 21; i++) begin
            step(1'b0, 1'b0, 8'h3F, {3'd0, 3'd7, 3'd0, 3'd3});
            if (i < PWM_PER && led[0]) highs++;
        end
        checks++;
        assert (highs === 3) else begin
            fails++;
            $error("FAIL pwm_duty3_highs observed=%0d expected=3", highs);
        end

        // ch0 ON / ch1 BLINK, then ch0 joins BLINK and must track ch1.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h09, 12'h000);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 8'h0A, 12'h000);
            checks++;
            assert (led[0] === led[1]) else begin
                fails++;
                $error("FAIL blink_join observed=%b expected=%b", led[0], led[1]);
            end
        end

        // Resync on a terminal-count cycle while phase is 0.
        for (int i = 0; i < 8 && (t % 8) != 3; i++) step(1'b0, 1'b0, 8'hAA, 12'h000);
        step(1'b0, 1'b1, 8'hAA, 12'h000);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 8'hAA, 12'h000);
            if (tick) begin k = i; break; end
        end
        checks++;
        assert (k === 4) else begin
            fails++;
            $error("FAIL sync_next_tick observed=%0d expected=4", k);
        end

        // Reset two cycles after a phase toggle, then restart timing.
        for (int i = 0; i < 8 && !tick; i++) step(1'b0, 1'b0, 8'hAA, 12'h000);
        step(1'b0, 1'b0, 8'hAA, 12'h000);
        step(1'b0, 1'b0, 8'hAA, 12'h000);
        step(1'b1, 1'b0, 8'hAA, 12'h000);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'hAA, 12'h000);

        // Random modes, duties, resyncs and resets.
        rm = 8'hAA; rd = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rm = 8'($urandom);
                rd = 12'($urandom);
            end
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), rm, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent LED channels, range 1..32.
REQ-002 Parameter HALF_PERIOD, default 5_000_000: clocks per blink half-period, range 2..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 24: prescaler counter width.
REQ-004 Parameter PWM_W, default 8: duty and PWM counter width, range 2..16.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port mode, input, 2*NUM_CH: per-channel mode; channel i uses bits [2i+1:2i]; 00 OFF, 01 ON, 10 BLINK, 11 PWM.
REQ-008 Port duty, input, PWM_W*NUM_CH: per-channel PWM duty; channel i uses bits [PWM_W*(i+1)-1:PWM_W*i].
REQ-009 Port sync_req, input, 1: single-cycle request to restart all timing phases.
REQ-010 Port led, output, NUM_CH: registered LED drive, active high.
REQ-011 Port tick, output, 1: registered one-cycle pulse marking each blink half-period boundary.

Function
REQ-012 Prescaler counter (CNT_W bits) SHALL increment every cycle and wrap to 0 after HALF_PERIOD-1 (terminal count).
REQ-013 tick SHALL be 1 in the cycle after the prescaler holds HALF_PERIOD-1, else 0; period exactly HALF_PERIOD cycles.
REQ-014 Shared blink phase bit SHALL toggle on every prescaler terminal count.
REQ-015 PWM counter (PWM_W bits) SHALL increment every cycle and wrap from 2^PWM_W-2 to 0; PWM period = 2^PWM_W-1 cycles.
REQ-016 OFF: led[i] SHALL be 0.
REQ-017 ON: led[i] SHALL be 1.
REQ-018 BLINK: led[i] SHALL equal the blink phase bit; all BLINK channels stay in phase.
REQ-019 PWM: led[i] SHALL be 1 iff PWM counter < duty[i] (unsigned).
REQ-020 PWM boundaries: duty=0 gives constant 0; duty=2^PWM_W-1 gives constant 1.
REQ-021 led SHALL reflect mode, duty and counter state one clock after sampling (latency 1), with no glitch or extra state.
REQ-022 A mode change SHALL NOT reset shared counters; a channel entering BLINK adopts the current phase.
REQ-023 sync_req=1 SHALL clear prescaler, blink phase and PWM counter to 0 on that edge; tick SHALL be 0 the following cycle.
REQ-024 If sync_req coincides with terminal count, sync_req SHALL win: no tick, no phase toggle.
REQ-025 Counter arithmetic SHALL be unsigned, with no overflow beyond the stated wrap points.

Reset
REQ-026 rst=1 SHALL set prescaler=0, blink phase=0, PWM counter=0, led=0, tick=0 at the next rising edge.
REQ-027 rst SHALL take priority over sync_req and all counting.
REQ-028 Asserting rst mid-operation SHALL abort all phases, so the first tick after release comes HALF_PERIOD cycles after deassertion.
REQ-029 mode and duty SHALL take effect from the first cycle after rst deasserts.

Verification (bench: NUM_CH=4, HALF_PERIOD=4, PWM_W=3)
REQ-030 Reset, all channels BLINK -> led=0000 for 4 cycles, then 1111 for 4, repeating; tick every 4th cycle.
REQ-031 ch0 PWM duty=3, ch1 duty=0, ch2 duty=7, ch3 OFF -> per 7-cycle period: led[0] high 3 cycles, led[1] always 0, led[2] always 1, led[3] always 0.
REQ-032 ch0 ON, ch1 BLINK; switch ch0 to BLINK mid-half-period -> led[0] matches led[1] from the next cycle.
REQ-033 sync_req pulsed on the terminal-count cycle -> no tick, phase unchanged; next tick exactly 4 cycles after the sync edge.
REQ-034 rst pulsed 2 cycles after a phase toggle -> led=0000, tick=0, restart timing as in REQ-030.
